led_scan_decoder: RTL and testbench

//  Receive end of the multiplexed 7-segment interface driven by Led_Display.

---
 rtl/led_scan_decoder.sv | 182 ++++++++++++++++++
 tb/tb_led_scan_decoder.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/led_scan_decoder.sv
// Receive side of a multiplexed 7-segment scan: waits for each digit to settle,
// decodes the segment pattern to a nibble and reassembles a 16-bit frame.
module led_scan_decoder #(
    parameter int SETTLE_CYCLES = 2,
    parameter bit SEG_ACT_LOW   = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  led_com,
    input  logic [7:0]  led_data,
    output logic [15:0] num_out,
    output logic        num_valid,
    output logic        num_chg,
    output logic        seg_err,
    output logic [1:0]  err_digit
);

    localparam int CW = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_WAIT,
        ST_SETTLE,
        ST_SAMPLE,
        ST_HOLD
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    com_q, com_d, com_prev_q, com_prev_d;
    logic [7:0]    data_q, data_d, data_prev_q, data_prev_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    seen_q, seen_d;
    logic [15:0]   shadow_q, shadow_d;
    logic [15:0]   num_out_q, num_out_d;
    logic          num_valid_q, num_valid_d;
    logic          num_chg_q, num_chg_d;
    logic          seg_err_q, seg_err_d;
    logic [1:0]    err_digit_q, err_digit_d;

    logic          change;
    logic [6:0]    seg_act;
    logic [4:0]    dec;
    logic [15:0]   shadow_n;
    logic [3:0]    seen_n;

    // Returns {code_ok, nibble}; dp is not part of the pattern.
    function automatic logic [4:0] decode(input logic [6:0] seg);
        logic [4:0] r;
        case (seg)
            7'h3F:   r = {1'b1, 4'h0};
            7'h06:   r = {1'b1, 4'h1};
            7'h5B:   r = {1'b1, 4'h2};
            7'h4F:   r = {1'b1, 4'h3};
            7'h66:   r = {1'b1, 4'h4};
            7'h6D:   r = {1'b1, 4'h5};
            7'h7D:   r = {1'b1, 4'h6};
            7'h07:   r = {1'b1, 4'h7};
            7'h7F:   r = {1'b1, 4'h8};
            7'h6F:   r = {1'b1, 4'h9};
            7'h77:   r = {1'b1, 4'hA};
            7'h7C:   r = {1'b1, 4'hB};
            7'h39:   r = {1'b1, 4'hC};
            7'h5E:   r = {1'b1, 4'hD};
            7'h79:   r = {1'b1, 4'hE};
            7'h71:   r = {1'b1, 4'hF};
            default: r = 5'b0_0000;
        endcase
        return r;
    endfunction

    always_comb begin
        com_d       = led_com;
        data_d      = led_data;
        com_prev_d  = com_q;
        data_prev_d = data_q;
        state_d     = state_q;
        cnt_d       = cnt_q;
        seen_d      = seen_q;
        shadow_d    = shadow_q;
        num_out_d   = num_out_q;
        num_valid_d = 1'b0;
        num_chg_d   = 1'b0;
        seg_err_d   = 1'b0;
        err_digit_d = err_digit_q;

        change  = {com_q, data_q} != {com_prev_q, data_prev_q};
        seg_act = SEG_ACT_LOW ? ~data_q[6:0] : data_q[6:0];
        dec     = decode(seg_act);

        shadow_n = shadow_q;
        shadow_n[{com_q, 2'b00} +: 4] = dec[3:0];
        seen_n = seen_q;
        seen_n[com_q] = 1'b1;

        case (state_q)
            ST_WAIT: begin
                if (change) begin
                    state_d = ST_SETTLE;
                    cnt_d   = CW'(1);
                end
            end
            ST_SETTLE: begin
                if (change) begin
                    cnt_d = CW'(1);
                end else if (cnt_q == CW'(SETTLE_CYCLES)) begin
                    state_d = ST_SAMPLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_SAMPLE: begin
                // A change landing on the sample cycle is a transient: re-settle instead.
                if (change) begin
                    state_d = ST_SETTLE;
                    cnt_d   = CW'(1);
                end else begin
                    state_d = ST_HOLD;
                    if (dec[4]) begin
                        shadow_d = shadow_n;
                        if (seen_n == 4'hF) begin
                            num_out_d   = shadow_n;
                            num_valid_d = 1'b1;
                            num_chg_d   = shadow_n != num_out_q;
                            seen_d      = 4'h0;
                        end else begin
                            seen_d = seen_n;
                        end
                    end else begin
                        seg_err_d   = 1'b1;
                        err_digit_d = com_q;
                        seen_d      = 4'h0;
                    end
                end
            end
            ST_HOLD: begin
                if (change) begin
                    state_d = ST_SETTLE;
                    cnt_d   = CW'(1);
                end
            end
            default: state_d = ST_WAIT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_WAIT;
            com_q       <= 2'd0;
            data_q      <= 8'd0;
            com_prev_q  <= 2'd0;
            data_prev_q <= 8'd0;
            cnt_q       <= '0;
            seen_q      <= 4'h0;
            shadow_q    <= 16'h0;
            num_out_q   <= 16'h0;
            num_valid_q <= 1'b0;
            num_chg_q   <= 1'b0;
            seg_err_q   <= 1'b0;
            err_digit_q <= 2'd0;
        end else begin
            state_q     <= state_d;
            com_q       <= com_d;
            data_q      <= data_d;
            com_prev_q  <= com_prev_d;
            data_prev_q <= data_prev_d;
            cnt_q       <= cnt_d;
            seen_q      <= seen_d;
            shadow_q    <= shadow_d;
            num_out_q   <= num_out_d;
            num_valid_q <= num_valid_d;
            num_chg_q   <= num_chg_d;
            seg_err_q   <= seg_err_d;
            err_digit_q <= err_digit_d;
        end
    end

    assign num_out   = num_out_q;
    assign num_valid = num_valid_q;
    assign num_chg   = num_chg_q;
    assign seg_err   = seg_err_q;
    assign err_digit = err_digit_q;

endmodule

// File: tb/tb_led_scan_decoder.sv
// Directed bench for led_scan_decoder: frame table plus hand-written sequences
// for latency, reset mid-frame, short dwell and active-low segments.
module tb_led_scan_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  led_com;
    logic [7:0]  led_data;
    logic [7:0]  led_data_n;

    logic [15:0] num_out, s3_num_out, al_num_out;
    logic        num_valid, s3_num_valid, al_num_valid;
    logic        num_chg, s3_num_chg, al_num_chg;
    logic        seg_err, s3_seg_err, al_seg_err;
    logic [1:0]  err_digit, s3_err_digit, al_err_digit;

    assign led_data_n = ~led_data;

    always #5 clk = ~clk;

    led_scan_decoder #(.SETTLE_CYCLES(2), .SEG_ACT_LOW(1'b0)) dut (
        .clk(clk), .rst(rst), .led_com(led_com), .led_data(led_data),
        .num_out(num_out), .num_valid(num_valid), .num_chg(num_chg),
        .seg_err(seg_err), .err_digit(err_digit)
    );

    led_scan_decoder #(.SETTLE_CYCLES(3), .SEG_ACT_LOW(1'b0)) dut_s3 (
        .clk(clk), .rst(rst), .led_com(led_com), .led_data(led_data),
        .num_out(s3_num_out), .num_valid(s3_num_valid), .num_chg(s3_num_chg),
        .seg_err(s3_seg_err), .err_digit(s3_err_digit)
    );

    led_scan_decoder #(.SETTLE_CYCLES(2), .SEG_ACT_LOW(1'b1)) dut_al (
        .clk(clk), .rst(rst), .led_com(led_com), .led_data(led_data_n),
        .num_out(al_num_out), .num_valid(al_num_valid), .num_chg(al_num_chg),
        .seg_err(al_seg_err), .err_digit(al_err_digit)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    int v_cnt, c_cnt, e_cnt, al_v_cnt, al_e_cnt, s3_v_cnt, s3_e_cnt;

    always @(negedge clk) begin
        if (num_valid)    v_cnt++;
        if (num_chg)      c_cnt++;
        if (seg_err)      e_cnt++;
        if (al_num_valid) al_v_cnt++;
        if (al_seg_err)   al_e_cnt++;
        if (s3_num_valid) s3_v_cnt++;
        if (s3_seg_err)   s3_e_cnt++;
    end

    task automatic clear_counts();
        v_cnt = 0; c_cnt = 0; e_cnt = 0;
        al_v_cnt = 0; al_e_cnt = 0; s3_v_cnt = 0; s3_e_cnt = 0;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] seg7(input logic [3:0] n);
        logic [7:0] s;
        case (n)
            4'h0: s = 8'h3F; 4'h1: s = 8'h06; 4'h2: s = 8'h5B; 4'h3: s = 8'h4F;
            4'h4: s = 8'h66; 4'h5: s = 8'h6D; 4'h6: s = 8'h7D; 4'h7: s = 8'h07;
            4'h8: s = 8'h7F; 4'h9: s = 8'h6F; 4'hA: s = 8'h77; 4'hB: s = 8'h7C;
            4'hC: s = 8'h39; 4'hD: s = 8'h5E; 4'hE: s = 8'h79; default: s = 8'h71;
        endcase
        return s;
    endfunction

    // Inputs change 1 time unit after a rising edge and hold for n edges.
    task automatic drive(input logic [1:0] c, input logic [7:0] d, input int n);
        led_com  = c;
        led_data = d;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_frame(input logic [15:0] val, input int dwell, input int bad,
                             input int glitch, input int first, input int last);
        logic [15:0] v;
        logic [7:0]  d;
        v = val;
        for (int k = first; k <= last; k++) begin
            d = (k == bad) ? 8'h00 : seg7(v[4*k +: 4]);
            if (k == glitch) begin
                drive(2'(k), d, 1);
                drive(2'(k), 8'h00, 1);
            end
            drive(2'(k), d, dwell);
        end
    endtask

    typedef struct {
        logic [15:0] val;
        int          bad;
        int          glitch;
        int          exp_v;
        int          exp_c;
        int          exp_e;
        logic [15:0] exp_num;
        logic [1:0]  exp_ed;
    } frame_t;

    frame_t tbl[9];
    int     lat;

    initial begin
        // val, bad digit, glitch digit, valid/chg/err pulse counts, num_out, err_digit
        tbl[0] = '{16'h1234, -1, -1, 1, 1, 0, 16'h1234, 2'd0};
        tbl[1] = '{16'h1234, -1, -1, 1, 0, 0, 16'h1234, 2'd0};
        tbl[2] = '{16'h1234, -1, -1, 1, 0, 0, 16'h1234, 2'd0};
        tbl[3] = '{16'hBEEF, -1, -1, 1, 1, 0, 16'hBEEF, 2'd0};
        tbl[4] = '{16'hBEEF, -1, -1, 1, 0, 0, 16'hBEEF, 2'd0};
        tbl[5] = '{16'h5A5A, -1,  1, 1, 1, 0, 16'h5A5A, 2'd0};
        tbl[6] = '{16'h1234,  2, -1, 0, 0, 1, 16'h5A5A, 2'd2};
        tbl[7] = '{16'h1234, -1, -1, 1, 1, 0, 16'h1234, 2'd2};
        tbl[8] = '{16'h1234, -1, -1, 1, 0, 0, 16'h1234, 2'd2};

        rst = 1'b1;
        led_com = 2'd0;
        led_data = 8'h00;
        clear_counts();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset num_out", num_out, 16'h0);
        check("reset num_valid", num_valid, 1'b0);
        check("reset num_chg", num_chg, 1'b0);
        check("reset seg_err", seg_err, 1'b0);
        check("reset err_digit", err_digit, 2'd0);
        check("reset al num_out", al_num_out, 16'h0);

        // Inputs held constant since reset: nothing may be emitted.
        clear_counts();
        drive(2'd0, 8'h00, 20);
        check("const valid count", v_cnt, 0);
        check("const err count", e_cnt, 0);
        check("const num_out", num_out, 16'h0);
        $display("const-input idle: valid=%0d err=%0d", v_cnt, e_cnt);

        for (int i = 0; i < 9; i++) begin
            clear_counts();
            run_frame(tbl[i].val, 8, tbl[i].bad, tbl[i].glitch, 0, 3);
            $display("frame %0d val=%h: num_out=%h valid=%0d chg=%0d err=%0d err_digit=%0d",
                     i, tbl[i].val, num_out, v_cnt, c_cnt, e_cnt, err_digit);
            check($sformatf("frame%0d valid", i), v_cnt, tbl[i].exp_v);
            check($sformatf("frame%0d chg", i), c_cnt, tbl[i].exp_c);
            check($sformatf("frame%0d err", i), e_cnt, tbl[i].exp_e);
            check($sformatf("frame%0d num_out", i), num_out, tbl[i].exp_num);
            check($sformatf("frame%0d err_digit", i), err_digit, tbl[i].exp_ed);
            check($sformatf("frame%0d al valid", i), al_v_cnt, tbl[i].exp_v);
            check($sformatf("frame%0d al err", i), al_e_cnt, tbl[i].exp_e);
            check($sformatf("frame%0d al num_out", i), al_num_out, tbl[i].exp_num);
        end

        // Latency: final digit at the pins -> num_valid after 1+2+1+1 edges.
        rst = 1'b1;
        #1;
        rst = 1'b0;
        run_frame(16'h1234, 8, -1, -1, 0, 2);
        led_com = 2'd3;
        led_data = seg7(4'h1);
        lat = 99;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (num_valid) begin
                lat = k;
                break;
            end
        end
        $display("latency: %0d edges, num_out=%h chg=%0b", lat, num_out, num_chg);
        check("latency", lat, 5);
        check("latency num_out", num_out, 16'h1234);
        check("latency num_chg", num_chg, 1'b1);
        drive(2'd3, seg7(4'h1), 3);

        // Reset after two digits sampled: everything cleared, needs 4 fresh digits.
        run_frame(16'hCAFE, 8, -1, -1, 0, 1);
        #3;
        rst = 1'b1;
        led_com = 2'd0;
        led_data = 8'h00;
        #1;
        check("midrst num_out", num_out, 16'h0);
        check("midrst num_valid", num_valid, 1'b0);
        check("midrst al num_out", al_num_out, 16'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_counts();
        run_frame(16'hCAFE, 8, -1, -1, 2, 3);
        check("postrst partial valid", v_cnt, 0);
        check("postrst partial num_out", num_out, 16'h0);
        clear_counts();
        run_frame(16'hCAFE, 8, -1, -1, 0, 3);
        $display("post-reset frame: num_out=%h valid=%0d chg=%0d al_num_out=%h",
                 num_out, v_cnt, c_cnt, al_num_out);
        check("postrst valid", v_cnt, 1);
        check("postrst chg", c_cnt, 1);
        check("postrst num_out", num_out, 16'hCAFE);
        check("postrst al num_out", al_num_out, 16'hCAFE);

        // Dwell shorter than the settle window: the SETTLE_CYCLES=3 instance never samples.
        clear_counts();
        for (int f = 0; f < 3; f++) run_frame(16'h1234, 2, -1, -1, 0, 3);
        $display("dwell-2 scan: s3 valid=%0d s3 err=%0d", s3_v_cnt, s3_e_cnt);
        check("short dwell s3 valid", s3_v_cnt, 0);
        check("short dwell s3 err", s3_e_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
